// File: rtl/plic_gen2.sv
// rtl/plic_gen2.sv - platform-level interrupt controller with level/edge gateways and one hart context
module plic_gen2 #(
    parameter int NUM_SRC = 31,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               plic_icb_cmd_valid,
    output logic               plic_icb_cmd_ready,
    input  logic [31:0]        plic_icb_cmd_addr,
    input  logic               plic_icb_cmd_read,
    input  logic [31:0]        plic_icb_cmd_wdata,
    input  logic [3:0]         plic_icb_cmd_wmask,
    output logic               plic_icb_rsp_valid,
    input  logic               plic_icb_rsp_ready,
    output logic               plic_icb_rsp_err,
    output logic [31:0]        plic_icb_rsp_rdata,
    input  logic [NUM_SRC:0]   plic_irq_port,
    output logic               core_ex_trap_valid_i,
    output logic [4:0]         core_ex_trap_id_i,
    input  logic               core_ex_trap_ready_o,
    input  logic               core_ex_trap_cplet_o,
    input  logic [4:0]         core_ex_trap_cplet_id_o
);

    localparam logic [27:0] A_IP     = 28'h0001000;
    localparam logic [27:0] A_TRIG   = 28'h0001080;
    localparam logic [27:0] A_IE     = 28'h0002000;
    localparam logic [27:0] A_THRESH = 28'h0200000;
    localparam logic [27:0] A_CLAIM  = 28'h0200004;
    localparam logic [31:0] NSRC     = NUM_SRC;

    logic [PRIO_W-1:0] r_prio [NUM_SRC:0];
    logic [NUM_SRC:0]  r_ie, r_trig, r_ip, r_insvc, r_latch, r_line_q;
    logic [PRIO_W-1:0] r_thresh;
    logic              r_rsp_valid, r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic              r_trap_valid;
    logic [4:0]        r_trap_id;

    logic [27:0]       w_addr;
    logic [4:0]        w_prio_idx;
    logic              w_is_prio, w_is_ip, w_is_trig, w_is_ie, w_is_thresh, w_is_claim, w_mapped;
    logic              w_cmd_hs, w_wr, w_core_claim, w_bus_claim, w_claim_any, w_bus_cplt;
    logic [NUM_SRC:0]  w_wr_vec, w_trig_chg, w_rise, w_claim_vec, w_cplt_vec;
    logic [NUM_SRC:0]  w_ip_nxt, w_insvc_nxt, w_latch_nxt;
    logic [31:0]       w_rdata;
    logic [4:0]        w_best_id;
    logic [PRIO_W-1:0] w_best_prio;
    logic              w_unused;

    assign w_unused = ^{plic_icb_cmd_wmask, plic_icb_cmd_addr[31:28], plic_irq_port[0]};

    assign w_addr      = plic_icb_cmd_addr[27:0];
    assign w_prio_idx  = w_addr[6:2];
    assign w_is_prio   = (w_addr[27:12] == 16'd0) && (w_addr[1:0] == 2'd0)
                         && ({22'd0, w_addr[11:2]} <= NSRC);
    assign w_is_ip     = (w_addr == A_IP);
    assign w_is_trig   = (w_addr == A_TRIG);
    assign w_is_ie     = (w_addr == A_IE);
    assign w_is_thresh = (w_addr == A_THRESH);
    assign w_is_claim  = (w_addr == A_CLAIM);
    assign w_mapped    = w_is_prio | w_is_ip | w_is_trig | w_is_ie | w_is_thresh | w_is_claim;

    assign plic_icb_cmd_ready = ~r_rsp_valid | plic_icb_rsp_ready;
    assign w_cmd_hs   = plic_icb_cmd_valid & plic_icb_cmd_ready;
    assign w_wr       = w_cmd_hs & ~plic_icb_cmd_read;
    assign w_wr_vec   = {plic_icb_cmd_wdata[NUM_SRC:1], 1'b0};
    assign w_trig_chg = (w_wr && w_is_trig) ? (r_trig ^ w_wr_vec) : '0;
    assign w_rise     = plic_irq_port & ~r_line_q;

    // The core handshake takes precedence; a colliding bus CLAIM read sees nothing.
    assign w_core_claim = r_trap_valid & core_ex_trap_ready_o;
    assign w_bus_claim  = w_cmd_hs & plic_icb_cmd_read & w_is_claim & r_trap_valid & ~w_core_claim;
    assign w_claim_any  = w_core_claim | w_bus_claim;
    assign w_bus_cplt   = w_wr & w_is_claim;

    always_comb begin
        w_claim_vec = '0;
        w_cplt_vec  = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_claim_vec[i] = w_claim_any && (r_trap_id == 5'(i));
            w_cplt_vec[i]  = r_insvc[i]
                             && ((core_ex_trap_cplet_o && (core_ex_trap_cplet_id_o == 5'(i)))
                                 || (w_bus_cplt && (plic_icb_cmd_wdata == 32'(i))));
        end
    end

    // Gateway: an edge seen while the source is busy parks in the latch until completion.
    always_comb begin
        w_ip_nxt    = r_ip;
        w_insvc_nxt = r_insvc;
        w_latch_nxt = r_latch;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (w_claim_vec[i]) begin
                w_ip_nxt[i]    = 1'b0;
                w_insvc_nxt[i] = 1'b1;
            end
            if (w_cplt_vec[i]) begin
                w_insvc_nxt[i] = 1'b0;
                if (r_trig[i] && r_latch[i]) begin
                    w_ip_nxt[i]    = 1'b1;
                    w_latch_nxt[i] = 1'b0;
                end
            end
            if (r_trig[i]) begin
                if (w_rise[i]) begin
                    if ((r_insvc[i] && !w_cplt_vec[i]) || w_claim_vec[i])
                        w_latch_nxt[i] = 1'b1;
                    else
                        w_ip_nxt[i] = 1'b1;
                end
            end else if (plic_irq_port[i] && !r_ip[i] && !r_insvc[i]) begin
                w_ip_nxt[i] = 1'b1;
            end
        end
        w_latch_nxt = w_latch_nxt & ~w_trig_chg;
    end

    // Ascending scan with strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (r_ip[i] && r_ie[i] && (r_prio[i] > w_best_prio)) begin
                w_best_id   = 5'(i);
                w_best_prio = r_prio[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (plic_icb_cmd_read) begin
            if (w_is_prio)   w_rdata[PRIO_W-1:0]  = r_prio[w_prio_idx];
            if (w_is_ip)     w_rdata[NUM_SRC:0]   = r_ip;
            if (w_is_trig)   w_rdata[NUM_SRC:0]   = r_trig;
            if (w_is_ie)     w_rdata[NUM_SRC:0]   = r_ie;
            if (w_is_thresh) w_rdata[PRIO_W-1:0]  = r_thresh;
            if (w_bus_claim) w_rdata[4:0]         = r_trap_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_SRC; i++) r_prio[i] <= '0;
            r_ie         <= '0;
            r_trig       <= '0;
            r_ip         <= '0;
            r_insvc      <= '0;
            r_latch      <= '0;
            r_line_q     <= '0;
            r_thresh     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_trap_valid <= 1'b0;
            r_trap_id    <= '0;
        end else begin
            r_line_q <= plic_irq_port;
            r_ip     <= w_ip_nxt;
            r_insvc  <= w_insvc_nxt;
            r_latch  <= w_latch_nxt;
            if (w_wr) begin
                if (w_is_prio && (w_prio_idx != 5'd0)) r_prio[w_prio_idx] <= plic_icb_cmd_wdata[PRIO_W-1:0];
                if (w_is_trig)   r_trig   <= w_wr_vec;
                if (w_is_ie)     r_ie     <= w_wr_vec;
                if (w_is_thresh) r_thresh <= plic_icb_cmd_wdata[PRIO_W-1:0];
            end
            // Blank one cycle after any claim so the claimed ID is never offered twice.
            if (w_claim_any) begin
                r_trap_valid <= 1'b0;
                r_trap_id    <= '0;
            end else begin
                r_trap_valid <= (w_best_id != 5'd0) && (w_best_prio > r_thresh);
                r_trap_id    <= w_best_id;
            end
            if (w_cmd_hs) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= ~w_mapped;
                r_rsp_rdata <= w_rdata;
            end else if (plic_icb_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign plic_icb_rsp_valid   = r_rsp_valid;
    assign plic_icb_rsp_err     = r_rsp_err;
    assign plic_icb_rsp_rdata   = r_rsp_rdata;
    assign core_ex_trap_valid_i = r_trap_valid;
    assign core_ex_trap_id_i    = r_trap_id;

endmodule

// File: tb/tb_plic_gen2.sv
// tb/tb_plic_gen2.sv - directed self-checking bench for plic_gen2
module tb_plic_gen2;

    localparam logic [31:0] A_IP     = 32'h0001000;
    localparam logic [31:0] A_TRIG   = 32'h0001080;
    localparam logic [31:0] A_IE     = 32'h0002000;
    localparam logic [31:0] A_THRESH = 32'h0200000;
    localparam logic [31:0] A_CLAIM  = 32'h0200004;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] irq;
    logic        trap_valid, core_ready, cplet;
    logic [4:0]  trap_id, cplet_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    plic_gen2 #(.NUM_SRC(31), .PRIO_W(3)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .plic_icb_cmd_valid      (cmd_valid),
        .plic_icb_cmd_ready      (cmd_ready),
        .plic_icb_cmd_addr       (cmd_addr),
        .plic_icb_cmd_read       (cmd_read),
        .plic_icb_cmd_wdata      (cmd_wdata),
        .plic_icb_cmd_wmask      (cmd_wmask),
        .plic_icb_rsp_valid      (rsp_valid),
        .plic_icb_rsp_ready      (rsp_ready),
        .plic_icb_rsp_err        (rsp_err),
        .plic_icb_rsp_rdata      (rsp_rdata),
        .plic_irq_port           (irq),
        .core_ex_trap_valid_i    (trap_valid),
        .core_ex_trap_id_i       (trap_id),
        .core_ex_trap_ready_o    (core_ready),
        .core_ex_trap_cplet_o    (cplet),
        .core_ex_trap_cplet_id_o (cplet_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] data, output logic err);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bus_rsp_valid addr=%h got=%b exp=1", addr, rsp_valid);
        end
        data = rsp_rdata;
        err  = rsp_err;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_bad++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (trap_valid !== 1'b0 || trap_id !== 5'd0) begin
            n_bad++; $display("FAIL rst_trap got=%b/%0d exp=0/0", trap_valid, trap_id); end
        rst = 1'b0;
        tick();
        for (int i = 0; i <= 31; i++) begin
            bus_op(1'b1, 32'(4 * i), 32'd0, d, e);
            n_cmp++; if (d !== 32'd0 || e !== 1'b0) begin
                n_bad++; $display("FAIL rst_prio%0d got=%h/%b exp=0/0", i, d, e); end
        end
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rst_ip got=%h/%b exp=0/0", d, e); end
        bus_op(1'b1, A_TRIG, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rst_trig got=%h/%b exp=0/0", d, e); end
        bus_op(1'b1, A_IE, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rst_ie got=%h/%b exp=0/0", d, e); end
        bus_op(1'b1, A_THRESH, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rst_thresh got=%h/%b exp=0/0", d, e); end
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rst_claim got=%h/%b exp=0/0", d, e); end
        bus_op(1'b1, 32'h0000080, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b1) begin n_bad++; $display("FAIL err_prio32 got=%h/%b exp=0/1", d, e); end
        bus_op(1'b1, 32'h0000100, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b1) begin n_bad++; $display("FAIL err_0x100 got=%h/%b exp=0/1", d, e); end
        bus_op(1'b1, 32'h0300000, 0, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b1) begin n_bad++; $display("FAIL err_0x300000 got=%h/%b exp=0/1", d, e); end
        bus_op(1'b0, 32'h0300000, 32'hFFFF_FFFF, d, e);
        n_cmp++; if (d !== 0 || e !== 1'b1) begin n_bad++; $display("FAIL err_wr got=%h/%b exp=0/1", d, e); end
    endtask

    task automatic test_level_arb();
        logic [31:0] d; logic e;
        bus_op(1'b0, 32'h0C, 32'd2, d, e);
        bus_op(1'b0, 32'h14, 32'd2, d, e);
        bus_op(1'b0, A_IE, 32'h28, d, e);
        bus_op(1'b0, A_THRESH, 32'd1, d, e);
        bus_op(1'b1, 32'h0C, 0, d, e);
        n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL prio3_rb got=%h exp=2", d); end
        irq = 32'h28;
        tick();
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL lvl_lat1 got=%b exp=0", trap_valid); end
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd3) begin
            n_bad++; $display("FAIL lvl_first got=%b/%0d exp=1/3", trap_valid, trap_id); end
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL claim_blank got=%b exp=0", trap_valid); end
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd5) begin
            n_bad++; $display("FAIL lvl_next got=%b/%0d exp=1/5", trap_valid, trap_id); end
        cplet = 1'b1; cplet_id = 5'd3;
        tick();
        cplet = 1'b0;
        tick();
        n_cmp++; if (trap_id !== 5'd5) begin n_bad++; $display("FAIL cplt_still5 got=%0d exp=5", trap_id); end
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd3) begin
            n_bad++; $display("FAIL lvl_repend got=%b/%0d exp=1/3", trap_valid, trap_id); end
    endtask

    task automatic test_threshold();
        logic [31:0] d; logic e;
        bus_op(1'b0, A_THRESH, 32'd2, d, e);
        tick(); tick();
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL thr2_valid got=%b exp=0", trap_valid); end
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'h28) begin n_bad++; $display("FAIL thr2_ip got=%h exp=28", d); end
        bus_op(1'b0, A_THRESH, 32'd1, d, e);
        tick(); tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd3) begin
            n_bad++; $display("FAIL thr1_valid got=%b/%0d exp=1/3", trap_valid, trap_id); end
        irq = 32'd0;
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL bus_claim3 got=%h exp=3", d); end
        tick();
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL bus_claim5 got=%h exp=5", d); end
        bus_op(1'b0, A_CLAIM, 32'd3, d, e);
        bus_op(1'b0, A_CLAIM, 32'd5, d, e);
        bus_op(1'b0, A_IE, 32'd0, d, e);
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL cleanup_ip got=%h exp=0", d); end
    endtask

    task automatic test_edge();
        logic [31:0] d; logic e;
        bus_op(1'b0, A_THRESH, 32'd0, d, e);
        bus_op(1'b0, A_TRIG, 32'h80, d, e);
        bus_op(1'b0, 32'h1C, 32'd1, d, e);
        bus_op(1'b0, A_IE, 32'h81, d, e);
        bus_op(1'b1, A_IE, 0, d, e);
        n_cmp++; if (d !== 32'h80) begin n_bad++; $display("FAIL ie_bit0 got=%h exp=80", d); end
        irq = 32'h80; tick(); irq = 32'd0;
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd7) begin
            n_bad++; $display("FAIL edge_valid got=%b/%0d exp=1/7", trap_valid, trap_id); end
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL edge_claim got=%h exp=7", d); end
        tick();
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL edge_claim2 got=%h exp=0", d); end
        irq = 32'h80; tick(); irq = 32'd0; tick();
        irq = 32'h80; tick(); irq = 32'd0; tick();
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL edge_held got=%h exp=0", d); end
        bus_op(1'b0, A_CLAIM, 32'd7, d, e);
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'h80) begin n_bad++; $display("FAIL edge_latch_ip got=%h exp=80", d); end
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd7) begin
            n_bad++; $display("FAIL edge_relatch got=%b/%0d exp=1/7", trap_valid, trap_id); end
        bus_op(1'b1, A_CLAIM, 0, d, e);
        n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL edge_claim3 got=%h exp=7", d); end
        bus_op(1'b0, A_CLAIM, 32'd7, d, e);
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL edge_once got=%h exp=0", d); end
        tick();
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL edge_idle got=%b exp=0", trap_valid); end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic e;
        irq = 32'h80; tick(); irq = 32'd0;
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd7) begin
            n_bad++; $display("FAIL col_valid got=%b/%0d exp=1/7", trap_valid, trap_id); end
        core_ready = 1'b1;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = A_CLAIM; cmd_wdata = 32'd0;
        tick();
        core_ready = 1'b0; cmd_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL col_bus got=%b/%h/%b exp=1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL col_blank got=%b exp=0", trap_valid); end
        cplet = 1'b1; cplet_id = 5'd0; tick(); cplet = 1'b0;
        bus_op(1'b0, A_CLAIM, 32'd31, d, e);
        bus_op(1'b0, A_CLAIM, 32'd0, d, e);
        tick();
        n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL badcplt_valid got=%b exp=0", trap_valid); end
        irq = 32'h80; tick(); irq = 32'd0; tick();
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL badcplt_insvc got=%h exp=0", d); end
        cplet = 1'b1; cplet_id = 5'd7; tick(); cplet = 1'b0;
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'h80) begin n_bad++; $display("FAIL core_cplt_ip got=%h exp=80", d); end
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_id !== 5'd7) begin
            n_bad++; $display("FAIL core_cplt_valid got=%b/%0d exp=1/7", trap_valid, trap_id); end
        core_ready = 1'b1; tick(); core_ready = 1'b0;
        cplet = 1'b1; cplet_id = 5'd7; tick(); cplet = 1'b0;
        bus_op(1'b1, A_IP, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL col_final_ip got=%h exp=0", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = A_IE;
        tick();
        cmd_addr = A_THRESH;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold%0d got=%b/%h/%b/%b exp=1/80/0/0", k, rsp_valid, rsp_rdata, rsp_err, cmd_ready); end
            tick();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_drop got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
        rst = 1'b0; rsp_ready = 1'b1;
        tick();
        bus_op(1'b1, A_IE, 0, d, e);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_ie_clear got=%h exp=0", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wmask = 4'hF; rsp_ready = 1'b1; irq = '0; core_ready = 1'b0; cplet = 1'b0; cplet_id = '0;
        test_reset();
        test_level_arb();
        test_threshold();
        test_edge();
        test_collision();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
